// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage owning the PC, IF/ID register, redirect and out-of-range halt
// Ports: clk/rst (sync, active-high); imem_addr/imem_instr to the instruction ROM;
// redirect_valid/redirect_pc from branch resolution; id_valid/id_ready handshake with
// id_instr/id_pc/id_pc_plus1 to decode; fault when the PC leaves [0, IMEM_DEPTH); fetch_count.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int unsigned IMEM_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus1,
  output logic        fault,
  output logic [31:0] fetch_count
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_n, instr_n, id_pc_n, plus1_n, count_n;
  logic valid_n, fault_n, stall, in_range;
  assign imem_addr = pc;
  assign stall = id_valid && !id_ready;
  assign in_range = pc < 32'(IMEM_DEPTH);
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      id_valid    <= 1'b0;
      id_instr    <= '0;
      id_pc       <= '0;
      id_pc_plus1 <= '0;
      fault       <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      id_valid    <= valid_n;
      id_instr    <= instr_n;
      id_pc       <= id_pc_n;
      id_pc_plus1 <= plus1_n;
      fault       <= fault_n;
      fetch_count <= count_n;
    end
  end
  // Redirect beats everything, including a stall: the held instruction is dropped.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    valid_n = id_valid;
    instr_n = id_instr;
    id_pc_n = id_pc;
    plus1_n = id_pc_plus1;
    fault_n = fault;
    count_n = fetch_count;
    if (redirect_valid) begin
      pc_n    = redirect_pc;
      valid_n = 1'b0;
      fault_n = 1'b0;
      state_n = RUN;
    end else if (state == BOOT) begin
      state_n = RUN;
    end else if (state == RUN && !stall) begin
      if (in_range) begin
        instr_n = imem_instr;
        id_pc_n = pc;
        plus1_n = pc + 32'd1;
        valid_n = 1'b1;
        pc_n    = pc + 32'd1;
        count_n = fetch_count + 32'd1;
      end else begin
        valid_n = 1'b0;
        fault_n = 1'b1;
        state_n = HALT;
      end
    end
  end
endmodule
